// File: rtl/alu_sequencer.sv
// Issue-side sequencer for the combinational ALU: latches one request, presents it to the ALU,
// waits out the ALU-reported delay and holds the captured result until writeback takes it.
package alu_sequencer_pkg;

    typedef enum logic [3:0] {
        ALU_OP_ADD   = 4'd0,
        ALU_OP_ADC   = 4'd1,
        ALU_OP_SUB   = 4'd2,
        ALU_OP_SBC   = 4'd3,
        ALU_OP_AND   = 4'd4,
        ALU_OP_OR    = 4'd5,
        ALU_OP_XOR   = 4'd6,
        ALU_OP_CMP   = 4'd7,
        ALU_OP_TEST1 = 4'd8,
        ALU_OP_SET1  = 4'd9,
        ALU_OP_CLR1  = 4'd10,
        ALU_OP_NOT1  = 4'd11
    } alu_operation_e;

    typedef struct packed {
        logic v;
        logic s;
        logic z;
        logic ac;
        logic p;
        logic cy;
    } flags_t;

endpackage

module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned DST_W      = 3,
    parameter int unsigned DELAY_BIAS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             req_valid,
    output logic             req_ready,
    input  alu_operation_e   req_op,
    input  logic [15:0]      req_ta,
    input  logic [15:0]      req_tb,
    input  logic             req_wide,
    input  logic [DST_W-1:0] req_dst,
    input  flags_t           flags_cur,
    output alu_operation_e   alu_operation,
    output logic [15:0]      alu_ta,
    output logic [15:0]      alu_tb,
    output logic             alu_wide,
    output flags_t           alu_flags_in,
    input  logic [15:0]      alu_result,
    input  logic [9:0]       alu_delay,
    input  flags_t           alu_flags,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [15:0]      wb_result,
    output flags_t           wb_flags,
    output logic [DST_W-1:0] wb_dst,
    output logic             wb_write,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e           state_q,     state_d;
    logic [9:0]       cnt_q,       cnt_d;
    alu_operation_e   op_q,        op_d;
    logic [15:0]      ta_q,        ta_d;
    logic [15:0]      tb_q,        tb_d;
    logic             wide_q,      wide_d;
    logic [DST_W-1:0] dst_q,       dst_d;
    flags_t           flags_q,     flags_d;
    logic [15:0]      wb_result_q, wb_result_d;
    flags_t           wb_flags_q,  wb_flags_d;
    logic [DST_W-1:0] wb_dst_q,    wb_dst_d;
    logic             wb_write_q,  wb_write_d;
    logic             accept_s;

    // Total wait = ALU delay plus static bias, clamped to what the 10-bit counter can hold.
    function automatic logic [9:0] sat_delay(input logic [9:0] d);
        logic [32:0] sum;
        sum = {23'd0, d} + {1'b0, 32'(DELAY_BIAS)};
        if (sum > 33'd1023) begin
            sat_delay = 10'd1023;
        end else begin
            sat_delay = sum[9:0];
        end
    endfunction

    function automatic logic writes_reg(input alu_operation_e op);
        writes_reg = !((op == ALU_OP_CMP) || (op == ALU_OP_TEST1));
    endfunction

    // State and datapath registers; everything else is decoded from these.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 10'd0;
            op_q        <= ALU_OP_ADD;
            ta_q        <= 16'd0;
            tb_q        <= 16'd0;
            wide_q      <= 1'b0;
            dst_q       <= {DST_W{1'b0}};
            flags_q     <= flags_t'(6'd0);
            wb_result_q <= 16'd0;
            wb_flags_q  <= flags_t'(6'd0);
            wb_dst_q    <= {DST_W{1'b0}};
            wb_write_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            ta_q        <= ta_d;
            tb_q        <= tb_d;
            wide_q      <= wide_d;
            dst_q       <= dst_d;
            flags_q     <= flags_d;
            wb_result_q <= wb_result_d;
            wb_flags_q  <= wb_flags_d;
            wb_dst_q    <= wb_dst_d;
            wb_write_q  <= wb_write_d;
        end
    end

    // Next-state and datapath update; with ce low every register holds.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wb_result_d = wb_result_q;
        wb_flags_d  = wb_flags_q;
        wb_dst_d    = wb_dst_q;
        wb_write_d  = wb_write_q;
        accept_s    = 1'b0;
        if (ce) begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        accept_s = 1'b1;
                        state_d  = ST_EXEC;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    wb_result_d = alu_result;
                    wb_flags_d  = alu_flags;
                    wb_dst_d    = dst_q;
                    wb_write_d  = writes_reg(op_q);
                    cnt_d       = sat_delay(alu_delay);
                    if (cnt_d == 10'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_d = cnt_q - 10'd1;
                    if (cnt_q <= 10'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    if (wb_ready) begin
                        if (req_valid) begin
                            accept_s = 1'b1;
                            state_d  = ST_EXEC;
                        end else begin
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Operand regs change only on accept so the ALU inputs stay stable through EXEC/WAIT/DONE.
        if (accept_s) begin
            op_d    = req_op;
            ta_d    = req_ta;
            tb_d    = req_tb;
            wide_d  = req_wide;
            dst_d   = req_dst;
            flags_d = flags_cur;
        end else begin
            op_d    = op_q;
            ta_d    = ta_q;
            tb_d    = tb_q;
            wide_d  = wide_q;
            dst_d   = dst_q;
            flags_d = flags_q;
        end
    end

    // Output decode from registered state and captured data.
    always_comb begin
        req_ready     = (state_q == ST_IDLE) || ((state_q == ST_DONE) && wb_ready);
        wb_valid      = (state_q == ST_DONE);
        busy          = (state_q != ST_IDLE);
        alu_operation = op_q;
        alu_ta        = ta_q;
        alu_tb        = tb_q;
        alu_wide      = wide_q;
        alu_flags_in  = flags_q;
        wb_result     = wb_result_q;
        wb_flags      = wb_flags_q;
        wb_dst        = wb_dst_q;
        wb_write      = wb_write_q;
    end

endmodule
